// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Execute-stage issue controller for a 64-bit LEGv8 ALU. Accepts
//             one register-read instruction at a time and decodes R-type and
//             I-type arithmetic/logic opcodes into ALU FS/C0 controls and A/B
//             operands. Captures the ALU result into a write-back holding
//             register and maintains the architectural NZCV flags.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            : clock, all state changes on the rising edge
//    rst_n          : synchronous reset, active low
//    i_in_valid     : instruction and operands present
//    o_in_ready     : block can accept (IDLE only)
//    i_instr        : LEGv8 instruction word
//    i_rn_data      : X[Rn]
//    i_rm_data      : X[Rm]
//    o_alu_A/B      : ALU operands
//    o_alu_FS/C0    : ALU function select and carry-in
//    i_alu_F        : ALU result
//    i_alu_status   : ALU status {V,C,N,Z}
//    o_wb_valid     : write-back result held
//    i_wb_ready     : write-back consumer accepts
//    o_wb_we        : register write enable (0 for Rd=31)
//    o_wb_rd        : destination register
//    o_wb_data      : result
//    o_flags        : architectural flags {V,C,N,Z}
//    o_illegal      : one-cycle pulse on an undecodable opcode
// ============================================================================
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_instr,
    input  logic [63:0] i_rn_data,
    input  logic [63:0] i_rm_data,
    output logic [63:0] o_alu_A,
    output logic [63:0] o_alu_B,
    output logic [4:0]  o_alu_FS,
    output logic        o_alu_C0,
    input  logic [63:0] i_alu_F,
    input  logic [3:0]  i_alu_status,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_rd,
    output logic [63:0] o_wb_data,
    output logic [3:0]  o_flags,
    output logic        o_illegal
);

    // ------------------------------------------------------------------
    // ALU function codes: {sel[2:0], Binv, Ainv}
    // ------------------------------------------------------------------
    localparam logic [4:0] c_FS_AND = 5'b00000;
    localparam logic [4:0] c_FS_OR  = 5'b00100;
    localparam logic [4:0] c_FS_ADD = 5'b01000;
    localparam logic [4:0] c_FS_SUB = 5'b01010;   // A + ~B + 1
    localparam logic [4:0] c_FS_XOR = 5'b01100;
    localparam logic [4:0] c_FS_LSL = 5'b10000;
    localparam logic [4:0] c_FS_LSR = 5'b10100;

    // R-type opcodes, instr[31:21]
    localparam logic [10:0] c_R_ADD  = 11'h458;
    localparam logic [10:0] c_R_ADDS = 11'h558;
    localparam logic [10:0] c_R_SUB  = 11'h658;
    localparam logic [10:0] c_R_SUBS = 11'h758;
    localparam logic [10:0] c_R_AND  = 11'h450;
    localparam logic [10:0] c_R_ANDS = 11'h750;
    localparam logic [10:0] c_R_ORR  = 11'h550;
    localparam logic [10:0] c_R_EOR  = 11'h650;
    localparam logic [10:0] c_R_LSL  = 11'h69B;
    localparam logic [10:0] c_R_LSR  = 11'h69A;

    // I-type opcodes, instr[31:22]
    localparam logic [9:0] c_I_ADDI  = 10'h244;
    localparam logic [9:0] c_I_ADDIS = 10'h2C4;
    localparam logic [9:0] c_I_SUBI  = 10'h344;
    localparam logic [9:0] c_I_SUBIS = 10'h3C4;
    localparam logic [9:0] c_I_ANDI  = 10'h248;
    localparam logic [9:0] c_I_ANDIS = 10'h3C8;
    localparam logic [9:0] c_I_ORRI  = 10'h2C8;
    localparam logic [9:0] c_I_EORI  = 10'h348;

    localparam logic [4:0] c_XZR = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Decode (combinational, only consumed at accept)
    // ------------------------------------------------------------------
    logic [10:0] w_op_r;
    logic [9:0]  w_op_i;
    logic [63:0] w_imm;
    logic [63:0] w_shamt;
    logic        w_legal;
    logic [4:0]  w_fs;
    logic        w_c0;
    logic [63:0] w_b;
    logic        w_setf;
    logic        w_unused_rn_field;

    assign w_op_r  = i_instr[31:21];
    assign w_op_i  = i_instr[31:22];
    assign w_imm   = {52'b0, i_instr[21:10]};
    assign w_shamt = {58'b0, i_instr[15:10]};

    // The Rn field only names the register; its value arrives on i_rn_data.
    assign w_unused_rn_field = ^i_instr[9:5];

    always_comb begin
        w_legal = 1'b0;
        w_fs    = c_FS_AND;
        w_c0    = 1'b0;
        w_b     = i_rm_data;
        w_setf  = 1'b0;
        // R-type match takes precedence; I-type is only tried on a miss.
        case (w_op_r)
            c_R_ADD:  begin w_legal = 1'b1; w_fs = c_FS_ADD; end
            c_R_ADDS: begin w_legal = 1'b1; w_fs = c_FS_ADD; w_setf = 1'b1; end
            c_R_SUB:  begin w_legal = 1'b1; w_fs = c_FS_SUB; w_c0 = 1'b1; end
            c_R_SUBS: begin w_legal = 1'b1; w_fs = c_FS_SUB; w_c0 = 1'b1; w_setf = 1'b1; end
            c_R_AND:  begin w_legal = 1'b1; w_fs = c_FS_AND; end
            c_R_ANDS: begin w_legal = 1'b1; w_fs = c_FS_AND; w_setf = 1'b1; end
            c_R_ORR:  begin w_legal = 1'b1; w_fs = c_FS_OR;  end
            c_R_EOR:  begin w_legal = 1'b1; w_fs = c_FS_XOR; end
            c_R_LSL:  begin w_legal = 1'b1; w_fs = c_FS_LSL; w_b = w_shamt; end
            c_R_LSR:  begin w_legal = 1'b1; w_fs = c_FS_LSR; w_b = w_shamt; end
            default: begin
                w_b = w_imm;
                case (w_op_i)
                    c_I_ADDI:  begin w_legal = 1'b1; w_fs = c_FS_ADD; end
                    c_I_ADDIS: begin w_legal = 1'b1; w_fs = c_FS_ADD; w_setf = 1'b1; end
                    c_I_SUBI:  begin w_legal = 1'b1; w_fs = c_FS_SUB; w_c0 = 1'b1; end
                    c_I_SUBIS: begin w_legal = 1'b1; w_fs = c_FS_SUB; w_c0 = 1'b1; w_setf = 1'b1; end
                    c_I_ANDI:  begin w_legal = 1'b1; w_fs = c_FS_AND; end
                    c_I_ANDIS: begin w_legal = 1'b1; w_fs = c_FS_AND; w_setf = 1'b1; end
                    c_I_ORRI:  begin w_legal = 1'b1; w_fs = c_FS_OR;  end
                    c_I_EORI:  begin w_legal = 1'b1; w_fs = c_FS_XOR; end
                    default:   begin w_legal = 1'b0; end
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_in_ready;
    logic [63:0] r_alu_a;
    logic [63:0] r_alu_b;
    logic [4:0]  r_alu_fs;
    logic        r_alu_c0;
    logic [4:0]  r_rd;
    logic        r_setf;
    logic        r_wb_valid;
    logic        r_wb_we;
    logic [4:0]  r_wb_rd;
    logic [63:0] r_wb_data;
    logic [3:0]  r_flags;
    logic        r_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Any pending result is dropped and flags are cleared.
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_alu_a    <= 64'd0;
            r_alu_b    <= 64'd0;
            r_alu_fs   <= 5'd0;
            r_alu_c0   <= 1'b0;
            r_rd       <= 5'd0;
            r_setf     <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 64'd0;
            r_flags    <= 4'd0;
            r_illegal  <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        if (w_legal) begin
                            r_alu_a    <= i_rn_data;
                            r_alu_b    <= w_b;
                            r_alu_fs   <= w_fs;
                            r_alu_c0   <= w_c0;
                            r_rd       <= i_instr[4:0];
                            r_setf     <= w_setf;
                            r_in_ready <= 1'b0;
                            r_state    <= S_EXEC;
                        end else begin
                            // Rejected without leaving IDLE; ALU controls keep
                            // their previous values.
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    // ALU has had a full cycle on the registered controls.
                    r_wb_data  <= i_alu_F;
                    r_wb_rd    <= r_rd;
                    r_wb_we    <= (r_rd != c_XZR);
                    r_wb_valid <= 1'b1;
                    if (r_setf) begin
                        r_flags <= i_alu_status;
                    end
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (i_wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_wb_we    <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_wb_valid <= 1'b0;
                    r_wb_we    <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_alu_A    = r_alu_a;
    assign o_alu_B    = r_alu_b;
    assign o_alu_FS   = r_alu_fs;
    assign o_alu_C0   = r_alu_c0;
    assign o_wb_valid = r_wb_valid;
    assign o_wb_we    = r_wb_we;
    assign o_wb_rd    = r_wb_rd;
    assign o_wb_data  = r_wb_data;
    assign o_flags    = r_flags;
    assign o_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Purpose  : Self-checking bench for alu_issue_ctrl. A behavioural 64-bit
//             ALU closes the loop; expected write-back records are queued at
//             issue and checked by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_instr;
    logic [63:0] i_rn_data;
    logic [63:0] i_rm_data;
    logic [63:0] o_alu_A;
    logic [63:0] o_alu_B;
    logic [4:0]  o_alu_FS;
    logic        o_alu_C0;
    logic [63:0] i_alu_F;
    logic [3:0]  i_alu_status;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic        o_wb_we;
    logic [4:0]  o_wb_rd;
    logic [63:0] o_wb_data;
    logic [3:0]  o_flags;
    logic        o_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  fs;
        logic        c0;
        logic [63:0] b;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_instr      (i_instr),
        .i_rn_data    (i_rn_data),
        .i_rm_data    (i_rm_data),
        .o_alu_A      (o_alu_A),
        .o_alu_B      (o_alu_B),
        .o_alu_FS     (o_alu_FS),
        .o_alu_C0     (o_alu_C0),
        .i_alu_F      (i_alu_F),
        .i_alu_status (i_alu_status),
        .o_wb_valid   (o_wb_valid),
        .i_wb_ready   (i_wb_ready),
        .o_wb_we      (o_wb_we),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_flags      (o_flags),
        .o_illegal    (o_illegal)
    );

    // Behavioural LEGv8 ALU, status {V,C,N,Z}
    logic [63:0] w_a2, w_b2;
    logic [64:0] w_sum;
    logic        w_v, w_c;
    always_comb begin
        w_a2  = o_alu_FS[0] ? ~o_alu_A : o_alu_A;
        w_b2  = o_alu_FS[1] ? ~o_alu_B : o_alu_B;
        w_sum = {1'b0, w_a2} + {1'b0, w_b2} + {64'd0, o_alu_C0};
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (o_alu_FS[4:2])
            3'd0: i_alu_F = w_a2 & w_b2;
            3'd1: i_alu_F = w_a2 | w_b2;
            3'd2: begin
                i_alu_F = w_sum[63:0];
                w_c     = w_sum[64];
                w_v     = (w_a2[63] == w_b2[63]) && (w_sum[63] != w_a2[63]);
            end
            3'd3: i_alu_F = w_a2 ^ w_b2;
            3'd4: i_alu_F = o_alu_A << o_alu_B[5:0];
            3'd5: i_alu_F = o_alu_A >> o_alu_B[5:0];
            default: i_alu_F = 64'd0;
        endcase
        i_alu_status = {w_v, w_c, i_alu_F[63], (i_alu_F == 64'd0)};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [5:0] sh, input logic [4:0] rn,
                                          input logic [4:0] rd);
        return {op, rm, sh, rn, rd};
    endfunction

    function automatic logic [31:0] itype(input logic [9:0] op, input logic [11:0] imm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, imm, rn, rd};
    endfunction

    function automatic exp_t mk(input logic [4:0] fs, input logic c0, input logic [63:0] b,
                                input logic we, input logic [4:0] rd,
                                input logic [63:0] data, input logic [3:0] flags);
        exp_t e;
        e.fs = fs; e.c0 = c0; e.b = b; e.we = we; e.rd = rd; e.data = data; e.flags = flags;
        return e;
    endfunction

    // Monitor: ALU controls in EXEC, write-back record at each handshake
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (!o_in_ready && !o_wb_valid && q.size() > 0) begin
                chk("exec_fs", {59'd0, o_alu_FS}, {59'd0, q[0].fs});
                chk("exec_c0", {63'd0, o_alu_C0}, {63'd0, q[0].c0});
                chk("exec_b",  o_alu_B, q[0].b);
            end
            if (o_wb_valid && i_wb_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_wb", 64'd1, 64'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("wb_we",    {63'd0, o_wb_we}, {63'd0, mon_e.we});
                    chk("wb_rd",    {59'd0, o_wb_rd}, {59'd0, mon_e.rd});
                    chk("wb_data",  o_wb_data, mon_e.data);
                    chk("wb_flags", {60'd0, o_flags}, {60'd0, mon_e.flags});
                end
            end
        end
    end

    // Present one instruction and let it be accepted at the next edge.
    task automatic accept(input logic [31:0] ins, input logic [63:0] rn, input logic [63:0] rm);
        @(posedge clk); #1;
        i_in_valid = 1'b1;
        i_instr    = ins;
        i_rn_data  = rn;
        i_rm_data  = rm;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        i_instr    = 32'h0;
        i_rn_data  = 64'h0;
        i_rm_data  = 64'h0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {63'd0, o_in_ready}, 64'd1);
    endtask

    task automatic do_op(input logic [31:0] ins, input logic [63:0] rn, input logic [63:0] rm,
                         input exp_t e);
        q.push_back(e);
        accept(ins, rn, rm);
        @(negedge clk);
        chk("exec_in_ready", {63'd0, o_in_ready}, 64'd0);
        chk("exec_wb_valid", {63'd0, o_wb_valid}, 64'd0);
        @(negedge clk);
        chk("wb_valid_t2", {63'd0, o_wb_valid}, 64'd1);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        i_in_valid = 1'b0;
        i_instr    = 32'h0;
        i_rn_data  = 64'h0;
        i_rm_data  = 64'h0;
        i_wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {63'd0, o_in_ready}, 64'd1);
        chk("rst_wb_valid", {63'd0, o_wb_valid}, 64'd0);
        chk("rst_flags",    {60'd0, o_flags},    64'd0);
        chk("rst_illegal",  {63'd0, o_illegal},  64'd0);
        chk("rst_wb_data",  o_wb_data,           64'd0);
        chk("rst_wb_we",    {63'd0, o_wb_we},    64'd0);
        chk("rst_alu_fs",   {59'd0, o_alu_FS},   64'd0);
        chk("rst_alu_a",    o_alu_A,             64'd0);

        // ADDS signed overflow: V=1, N=1
        do_op(rtype(11'h558, 5'd2, 6'd0, 5'd1, 5'd3), 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
              mk(5'b01000, 1'b0, 64'd1, 1'b1, 5'd3, 64'h8000_0000_0000_0000, 4'b1010));

        // SUBS to XZR acts as CMP: C=1, Z=1, no register write
        do_op(rtype(11'h758, 5'd2, 6'd0, 5'd1, 5'd31), 64'd5, 64'd5,
              mk(5'b01010, 1'b1, 64'd5, 1'b0, 5'd31, 64'd0, 4'b0101));

        // LSL by 63, flags unchanged
        do_op(rtype(11'h69B, 5'd0, 6'd63, 5'd1, 5'd4), 64'd1, 64'hDEAD,
              mk(5'b10000, 1'b0, 64'd63, 1'b1, 5'd4, 64'h8000_0000_0000_0000, 4'b0101));

        // ANDI with 0xFFF, flags unchanged
        do_op(itype(10'h248, 12'hFFF, 5'd2, 5'd6), 64'h1234_5678, 64'd0,
              mk(5'b00000, 1'b0, 64'hFFF, 1'b1, 5'd6, 64'h678, 4'b0101));

        // EORI
        do_op(itype(10'h348, 12'h0FF, 5'd2, 5'd8), 64'hF0F, 64'd0,
              mk(5'b01100, 1'b0, 64'hFF, 1'b1, 5'd8, 64'hFF0, 4'b0101));

        // Write-back stall with an ignored in_valid pulse
        i_wb_ready = 1'b0;
        q.push_back(mk(5'b00100, 1'b0, 64'h0F, 1'b1, 5'd5, 64'hFF, 4'b0101));
        accept(rtype(11'h550, 5'd2, 6'd0, 5'd1, 5'd5), 64'hF0, 64'h0F);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_wb_valid", {63'd0, o_wb_valid}, 64'd1);
            chk("stall_wb_data",  o_wb_data,           64'hFF);
            chk("stall_wb_rd",    {59'd0, o_wb_rd},    64'd5);
            chk("stall_in_ready", {63'd0, o_in_ready}, 64'd0);
            if (i == 1) begin
                i_in_valid = 1'b1;
                i_instr    = rtype(11'h558, 5'd2, 6'd0, 5'd1, 5'd9);
                i_rn_data  = 64'h7FFF_FFFF_FFFF_FFFF;
                i_rm_data  = 64'd1;
            end else if (i == 2) begin
                i_in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        i_wb_ready = 1'b1;
        @(negedge clk);
        chk("release_wb_valid", {63'd0, o_wb_valid}, 64'd1);
        @(negedge clk);
        chk("release_idle", {63'd0, o_in_ready}, 64'd1);
        chk("release_wb_off", {63'd0, o_wb_valid}, 64'd0);
        chk("release_flags", {60'd0, o_flags}, 64'b0101);

        // Illegal opcode
        accept(32'hFFFF_FFFF, 64'd1, 64'd1);
        @(negedge clk);
        chk("illegal_pulse",    {63'd0, o_illegal},  64'd1);
        chk("illegal_in_ready", {63'd0, o_in_ready}, 64'd1);
        chk("illegal_no_wb",    {63'd0, o_wb_valid}, 64'd0);
        @(negedge clk);
        chk("illegal_end",      {63'd0, o_illegal},  64'd0);
        chk("illegal_ready2",   {63'd0, o_in_ready}, 64'd1);
        chk("illegal_no_wb2",   {63'd0, o_wb_valid}, 64'd0);
        chk("illegal_flags",    {60'd0, o_flags},    64'b0101);

        // Reset during EXEC of an ADDS
        accept(rtype(11'h558, 5'd2, 6'd0, 5'd1, 5'd3), 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_wb_valid", {63'd0, o_wb_valid}, 64'd0);
            chk("rstmid_flags",    {60'd0, o_flags},    64'd0);
            chk("rstmid_in_ready", {63'd0, o_in_ready}, 64'd1);
        end

        // Normal ADD after reset
        do_op(rtype(11'h458, 5'd2, 6'd0, 5'd1, 5'd7), 64'd10, 64'd20,
              mk(5'b01000, 1'b0, 64'd20, 1'b1, 5'd7, 64'd30, 4'b0000));

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
